isa_dma_responder: RTL
======================

Name: isa_dma_responder

Overview:
ISA DMA responder for the CT2960 riser host in the 8 MHz bus clock domain. It answers card DRQ requests (DRQ1/3/5/7) with DACK, AEN and an IOR or IOW strobe, and moves data between the ISA data bus and an internal FIFO serviced by the register file / HPS side. It is the host end of the card's DMA handshake and complements the programmed-I/O bus interface.

Parameters:
FIFO_DEPTH, 16, FIFO entries (power of two, >=2), each 16 bits
STROBE_CYCLES, 3, clk cycles IOR_n/IOW_n held low per transfer (>=1)
HOLD_CYCLES, 1, clk cycles DACK held after strobe release (>=1)

Ports:
clk  in  1  bus clock (8 MHz)
reset  in  1  asynchronous, active-low reset
drq  in  4  card DMA requests, active-high; [0]=DRQ1 [1]=DRQ3 [2]=DRQ5 [3]=DRQ7
dack_n  out  4  DMA acknowledges, active-low, same index map as drq
aen  out  1  high while DMA cycle owns the bus (ACK..HOLD)
ior_n  out  1  I/O read strobe, active-low (card-to-host transfers)
iow_n  out  1  I/O write strobe, active-low (host-to-card transfers)
data_bus_in  in  16  ISA data bus sample
data_bus_out  out  16  ISA data bus drive value
data_oe  out  1  high while data_bus_out must be driven
start  in  1  one-cycle pulse: arm a transfer block
chan_sel  in  2  channel index for the block, sampled on start
dir  in  1  1 = card-to-host (IOR), 0 = host-to-card (IOW); sampled on start
count  in  16  transfers minus one, sampled on start
abort  in  1  one-cycle pulse: stop the block
fifo_wr_en  in  1  HPS push (used when dir=0)
fifo_wr_data  in  16  HPS push data
fifo_rd_en  in  1  HPS pop (used when dir=1)
fifo_rd_data  out  16  FIFO head, valid when fifo_empty=0
fifo_full  out  1  FIFO full
fifo_empty  out  1  FIFO empty
busy  out  1  block in progress
tc  out  1  one-cycle pulse with the HOLD of the final transfer
done  out  1  one-cycle pulse when block ends (TC or abort)

Behaviour:
- Reset (async, immediate): dack_n=4'hF, aen=0, ior_n=1, iow_n=1, data_oe=0, data_bus_out=0, busy=0, tc=0, done=0, FIFO empty, FSM=IDLE.
- FSM states: IDLE, WAIT, ACK, STROBE, HOLD, DONE.
- IDLE: start latches chan_sel/dir/count into the remaining counter; busy=1 next cycle; -> WAIT. If dir=1, start also flushes the FIFO. start while busy is ignored.
- WAIT: -> ACK when drq[ch]=1 and (dir=1 ? !fifo_full : !fifo_empty). drq on other channels is ignored.
- ACK (1 cycle): dack_n[ch]=0, aen=1. For dir=0, data_oe=1 and data_bus_out=FIFO head.
- STROBE (STROBE_CYCLES cycles): ior_n or iow_n low. dir=1: sample data_bus_in on the last STROBE cycle and push it. dir=0: pop on the last STROBE cycle. data_oe stays high through HOLD.
- 8-bit channels (ch 0,1): dir=1 stores {8'h00, D[7:0]}. dir=0 drives {8'h00, head[7:0]}. 16-bit channels (ch 2,3) use full width.
- HOLD (HOLD_CYCLES cycles): strobes high, dack_n[ch]/aen still asserted. On exit: if remaining==0, -> DONE with tc pulsed in the first HOLD cycle; else decrement remaining and -> WAIT. Single-transfer mode: DACK is released between every transfer, even if drq stays high.
- DONE (1 cycle): done=1, busy=0 next cycle; -> IDLE.
- abort in WAIT: -> DONE, no tc. abort in ACK/STROBE/HOLD: the current transfer completes, then -> DONE with no tc (tc is still asserted if it was the final transfer). abort in IDLE: no effect.
- count=0 means exactly one transfer. count=16'hFFFF means 65536 transfers; the counter does not wrap early.
- FIFO: synchronous, first-word fall-through. HPS push when full and HPS pop when empty are ignored. Simultaneous push and pop on a non-empty, non-full FIFO keeps the occupancy unchanged. The HPS push port is ignored while busy with dir=1; the HPS pop port is ignored while busy with dir=0.
- Outputs are registered; no combinational path from drq to dack_n.

Optional Feature:
DMA_AUTOINIT_EN: when defined, a start input autoinit (1 bit, sampled on start) is added. If set, on terminal count the counter reloads the latched count, tc and done both pulse, busy stays 1, and the FSM returns to WAIT; only abort ends the block. When undefined, the port is absent and every block ends at terminal count.

Test Plan:
- Reset asserted mid-STROBE -> ior_n=1, dack_n=4'hF, aen=0, busy=0 in the same cycle; FIFO empty after release.
- start ch=2, dir=1, count=3, drq[2] held high, bus D=16'hA5C3 -> 4 ACK/STROBE/HOLD sequences, each with dack_n=4'b1011; FIFO holds 4 x 16'hA5C3; tc and done each pulse once.
- start ch=0, dir=1, count=0, D=16'h12FE -> FIFO entry is 16'h00FE; ior_n low for exactly 3 cycles.
- Preload FIFO with 16'h1111, 16'h2222; start ch=3, dir=0, count=2 -> two IOW cycles drive 1111 then 2222; FSM waits in WAIT with fifo_empty=1 until a third push of 16'h3333, then completes.
- dir=1, FIFO_DEPTH=16, no HPS pops, count=19 -> stalls in WAIT after 16 transfers with dack_n idle; popping one entry releases one transfer.
- abort during STROBE of transfer 2 of count=5 -> that transfer completes, then done pulses, tc=0, busy=0.

Source files
------------

// File: rtl/isa_dma_responder.sv
// rtl/isa_dma_responder.sv - ISA DMA responder: DRQ/DACK/AEN/IOR/IOW handshake with a 16-bit FWFT FIFO
// Optional feature macro: DMA_AUTOINIT_EN (adds autoinit input, block reloads at terminal count).
module isa_dma_responder #(
    parameter int FIFO_DEPTH    = 16,
    parameter int STROBE_CYCLES = 3,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  drq,
    output logic [3:0]  dack_n,
    output logic        aen,
    output logic        ior_n,
    output logic        iow_n,
    input  logic [15:0] data_bus_in,
    output logic [15:0] data_bus_out,
    output logic        data_oe,
    input  logic        start,
    input  logic [1:0]  chan_sel,
    input  logic        dir,
    input  logic [15:0] count,
    input  logic        abort,
    input  logic        fifo_wr_en,
    input  logic [15:0] fifo_wr_data,
    input  logic        fifo_rd_en,
    output logic [15:0] fifo_rd_data,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        busy,
    output logic        tc,
    output logic        done
`ifdef DMA_AUTOINIT_EN
    ,
    input  logic        autoinit
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ACK, S_STROBE, S_HOLD, S_DONE
    } state_e;

    state_e      state_q;
    logic [1:0]  ch_q;
    logic        dir_q;
    logic [15:0] remaining_q;
    logic [7:0]  phase_q;
    logic        abort_pend_q;
    logic [3:0]  dack_n_q;
    logic        aen_q;
    logic        ior_n_q;
    logic        iow_n_q;
    logic        data_oe_q;
    logic [15:0] data_bus_out_q;
    logic        busy_q;
    logic        tc_q;
    logic        done_q;
`ifdef DMA_AUTOINIT_EN
    logic [15:0] count_q;
    logic        autoinit_q;
`endif

    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        full;
    logic        empty;
    logic        active;
    logic        wide;
    logic        strobe_last;
    logic        flush;
    logic        push;
    logic        pop;
    logic        ready;
    logic [15:0] head;
    logic [15:0] push_data;

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head        = mem[rd_ptr_q[AW-1:0]];
    assign active      = (state_q != S_IDLE);
    assign wide        = ch_q[1];
    assign strobe_last = (state_q == S_STROBE) && (phase_q == STROBE_LAST);
    assign flush       = (state_q == S_IDLE) && start && dir;
    assign ready       = dir_q ? !full : !empty;

    // The DMA engine owns one FIFO port for the direction of the active block; HPS owns the other.
    assign push      = ((active && dir_q) ? strobe_last : fifo_wr_en) && !full;
    assign pop       = ((active && !dir_q) ? strobe_last : fifo_rd_en) && !empty;
    assign push_data = (active && dir_q) ? (wide ? data_bus_in : {8'h00, data_bus_in[7:0]})
                                         : fifo_wr_data;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            ch_q           <= 2'd0;
            dir_q          <= 1'b0;
            remaining_q    <= 16'd0;
            phase_q        <= 8'd0;
            abort_pend_q   <= 1'b0;
            dack_n_q       <= 4'hF;
            aen_q          <= 1'b0;
            ior_n_q        <= 1'b1;
            iow_n_q        <= 1'b1;
            data_oe_q      <= 1'b0;
            data_bus_out_q <= 16'd0;
            busy_q         <= 1'b0;
            tc_q           <= 1'b0;
            done_q         <= 1'b0;
`ifdef DMA_AUTOINIT_EN
            count_q        <= 16'd0;
            autoinit_q     <= 1'b0;
`endif
        end else begin
            tc_q   <= 1'b0;
            done_q <= 1'b0;
            // An abort mid-transfer is remembered so the current transfer finishes cleanly.
            if (abort && (state_q inside {S_ACK, S_STROBE, S_HOLD})) begin
                abort_pend_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ch_q         <= chan_sel;
                        dir_q        <= dir;
                        remaining_q  <= count;
                        busy_q       <= 1'b1;
                        abort_pend_q <= 1'b0;
                        state_q      <= S_WAIT;
`ifdef DMA_AUTOINIT_EN
                        count_q      <= count;
                        autoinit_q   <= autoinit;
`endif
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (drq[ch_q] && ready) begin
                        dack_n_q <= ~(4'b0001 << ch_q);
                        aen_q    <= 1'b1;
                        if (!dir_q) begin
                            data_oe_q      <= 1'b1;
                            data_bus_out_q <= wide ? head : {8'h00, head[7:0]};
                        end
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    phase_q <= 8'd0;
                    if (dir_q) ior_n_q <= 1'b0;
                    else       iow_n_q <= 1'b0;
                    state_q <= S_STROBE;
                end
                S_STROBE: begin
                    if (phase_q == STROBE_LAST) begin
                        ior_n_q <= 1'b1;
                        iow_n_q <= 1'b1;
                        phase_q <= 8'd0;
                        tc_q    <= (remaining_q == 16'd0);
                        state_q <= S_HOLD;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (phase_q == HOLD_LAST) begin
                        dack_n_q  <= 4'hF;
                        aen_q     <= 1'b0;
                        data_oe_q <= 1'b0;
                        if (abort_pend_q || abort) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (remaining_q == 16'd0) begin
`ifdef DMA_AUTOINIT_EN
                            done_q <= 1'b1;
                            if (autoinit_q) begin
                                remaining_q <= count_q;
                                state_q     <= S_WAIT;
                            end else begin
                                state_q <= S_DONE;
                            end
`else
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
`endif
                        end else begin
                            remaining_q <= remaining_q - 16'd1;
                            state_q     <= S_WAIT;
                        end
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dack_n       = dack_n_q;
    assign aen          = aen_q;
    assign ior_n        = ior_n_q;
    assign iow_n        = iow_n_q;
    assign data_oe      = data_oe_q;
    assign data_bus_out = data_bus_out_q;
    assign busy         = busy_q;
    assign tc           = tc_q;
    assign done         = done_q;
    assign fifo_rd_data = head;
    assign fifo_full    = full;
    assign fifo_empty   = empty;

endmodule
